// File: rtl/btn_led_ctrl.sv
// -----------------------------------------------------------------------------
// btn_led_ctrl
//
// Button-to-LED controller. Each raw push-button input is passed through a
// 2-flop synchroniser, debounced with a per-channel stability counter and
// edge-detected. Each channel drives two LEDs: a level LED that follows the
// debounced button, and a toggle LED that flips on every accepted press.
//
// Optional feature (macro BTN_LED_BLINK_EN):
//   When defined, a free-running blink counter gates the toggle LEDs with a
//   phase bit that inverts every BLINK_DIV clocks. When undefined, the counter
//   and phase do not exist and the toggle LEDs are steady.
//
// Parameters:
//   N_BTN           number of button channels (LED count is 2*N_BTN)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change (>=1)
//   BLINK_DIV       blink half-period in clocks (>=2), blink build only
//
// Ports:
//   clk        in   1        system clock, rising edge
//   rstn       in   1        synchronous active-low reset
//   btn        in   N_BTN    raw asynchronous button levels, 1 = pressed
//   led        out  2*N_BTN  [i] debounced level, [N_BTN+i] toggle LED
//   btn_press  out  N_BTN    one-cycle pulse per accepted 0->1 transition
// -----------------------------------------------------------------------------
module btn_led_ctrl #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int BLINK_DIV       = 3000000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_BTN-1:0]     btn,
  output logic [2*N_BTN-1:0]   led,
  output logic [N_BTN-1:0]     btn_press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard on the parameter ranges.
  if (DEBOUNCE_CYCLES < 1 || BLINK_DIV < 2) begin : g_param_check
    $error("btn_led_ctrl: DEBOUNCE_CYCLES must be >= 1 and BLINK_DIV >= 2");
  end

  logic [N_BTN-1:0]   r_sync1;
  logic [N_BTN-1:0]   r_sync2;
  logic [N_BTN-1:0]   r_stable;
  logic [N_BTN-1:0]   r_toggle;
  logic [CW-1:0]      r_cnt [N_BTN];
  logic [2*N_BTN-1:0] r_led;
  logic [N_BTN-1:0]   r_press;

  logic [N_BTN-1:0]   w_accept;
  logic [N_BTN-1:0]   w_rise;
  logic [N_BTN-1:0]   w_stable_nxt;
  logic [N_BTN-1:0]   w_toggle_nxt;
  logic [CW-1:0]      w_cnt_nxt [N_BTN];
  logic [N_BTN-1:0]   w_tog_led;

  // Debounce: a channel's counter only runs while the synchronised level
  // disagrees with the accepted level. Reaching DEBOUNCE_CYCLES-1 on a
  // mismatch accepts the new level; any agreement before that throws the
  // partial count away, so the counter can never wrap.
  always_comb begin
    w_accept     = '0;
    w_rise       = '0;
    w_stable_nxt = r_stable;
    w_toggle_nxt = r_toggle;
    for (int i = 0; i < N_BTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_accept[i]     = 1'b1;
          w_stable_nxt[i] = r_sync2[i];
          w_rise[i]       = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
    w_toggle_nxt = r_toggle ^ w_rise;
  end

`ifdef BTN_LED_BLINK_EN
  localparam int            BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          w_wrap;
  logic          w_phase_nxt;

  always_comb begin
    w_wrap      = (r_blink_cnt == BLINK_LAST);
    w_phase_nxt = r_phase ^ w_wrap;
    // Gate with the next phase so the LED changes on the same edge as phase.
    w_tog_led   = w_toggle_nxt & {N_BTN{w_phase_nxt}};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + BW'(1);
      r_phase     <= w_phase_nxt;
    end
  end
`else
  always_comb begin
    w_tog_led = w_toggle_nxt;
  end
`endif

  // LEDs and the press pulse are loaded from the next-state values so they
  // change on the very edge the debounced level is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_toggle <= '0;
      r_led    <= '0;
      r_press  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= btn;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_toggle <= w_toggle_nxt;
      r_led    <= {w_tog_led, w_stable_nxt};
      r_press  <= w_rise;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign led       = r_led;
  assign btn_press = r_press;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_led_ctrl
//
// Bench for btn_led_ctrl with N_BTN=3, DEBOUNCE_CYCLES=4, BLINK_DIV=8.
// Expected {led, btn_press} values are pushed per clock cycle when stimulus is
// applied and popped on the falling edge of the cycle they belong to.
// Define BTN_LED_BLINK_EN for both files to exercise the blink build.
// -----------------------------------------------------------------------------
module tb_btn_led_ctrl;

  localparam int N_BTN = 3;
  localparam int DEB   = 4;
  localparam int BDIV  = 8;
  localparam int LAT   = DEB + 2;
  localparam int W     = 16 + 2 * N_BTN + N_BTN;

  // ---------------------------------------------------------------- clock/reset
  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic [N_BTN-1:0] btn  = '0;
  logic [2*N_BTN-1:0] led;
  logic [N_BTN-1:0] btn_press;

  int cyc      = 0;
  int last_rst = 0;
  int total    = 0;
  int bad      = 0;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_led_ctrl #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_DIV      (BDIV)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn      (btn),
    .led      (led),
    .btn_press(btn_press)
  );

  // ---------------------------------------------------------------- checker
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, got, exp);
    end
  endtask

  // Expected LED vector for the state that holds after edge c.
  function automatic logic [2*N_BTN-1:0] mk_led(input int c, input logic [N_BTN-1:0] lvl,
                                                 input logic [N_BTN-1:0] tog);
    logic [N_BTN-1:0] t;
    t = tog;
`ifdef BTN_LED_BLINK_EN
    if ((((c - last_rst) / BDIV) % 2) == 1) t = '0;
`endif
    return {t, lvl};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rng(input int c0, input int c1, input logic [N_BTN-1:0] lvl,
                          input logic [N_BTN-1:0] tog, input logic [N_BTN-1:0] prs);
    for (int c = c0; c <= c1; c++) begin
      exp_q.push_back({16'(c), mk_led(c, lvl, tog), prs});
    end
  endtask

  task automatic do_reset(input int n);
    int t;
    rstn = 1'b0;
    t = cyc;
    push_rng(t + 1, t + n, '0, '0, '0);
    repeat (n) tick();
    rstn = 1'b1;
    last_rst = cyc;
  endtask

  // Drive a new button vector and hold it for 'hold' cycles; the accepted
  // change shows up LAT edges after the drive edge.
  task automatic run_press(input logic [N_BTN-1:0] v,
                           input logic [N_BTN-1:0] old_lvl, input logic [N_BTN-1:0] new_lvl,
                           input logic [N_BTN-1:0] old_tog, input logic [N_BTN-1:0] new_tog,
                           input logic [N_BTN-1:0] prs, input int hold);
    int t;
    btn = v;
    t = cyc;
    push_rng(t + 1, t + LAT - 1, old_lvl, old_tog, '0);
    push_rng(t + LAT, t + LAT, new_lvl, new_tog, prs);
    push_rng(t + LAT + 1, t + hold, new_lvl, new_tog, '0);
    repeat (hold) tick();
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    while (exp_q.size() > 0 && exp_q[0][W-1:W-16] == cyc[15:0]) begin
      e = exp_q.pop_front();
      chk("led", 8'(led), 8'(e[W-17:N_BTN]));
      chk("btn_press", 8'(btn_press), 8'(e[N_BTN-1:0]));
    end
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int t;
    do_reset(2);

    // Glitch shorter than the debounce window is discarded.
    btn = 3'b001;
    t = cyc;
    push_rng(t + 1, t + 10, '0, '0, '0);
    repeat (3) tick();
    btn = 3'b000;
    repeat (7) tick();

    // Clean press and release on channel 0.
    run_press(3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 10);
    run_press(3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 10);

    // Press / release / press / release on channel 1.
    run_press(3'b010, 3'b000, 3'b010, 3'b001, 3'b011, 3'b010, 10);
    run_press(3'b000, 3'b010, 3'b000, 3'b011, 3'b011, 3'b000, 10);
    run_press(3'b010, 3'b000, 3'b010, 3'b011, 3'b001, 3'b010, 10);
    run_press(3'b000, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000, 10);

    // Simultaneous presses from a clean reset.
    do_reset(1);
    run_press(3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 10);
    run_press(3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b000, 10);

    // Reset in the middle of a debounce on channel 2, button kept held.
    btn = 3'b100;
    t = cyc;
    push_rng(t + 1, t + 3, 3'b000, 3'b111, '0);
    repeat (3) tick();
    do_reset(1);
    run_press(3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b100, 10);
    run_press(3'b000, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000, 10);

    // Latch channel 0 and watch its toggle LED (blinks in the blink build).
    run_press(3'b001, 3'b000, 3'b001, 3'b100, 3'b101, 3'b001, 10);
    run_press(3'b000, 3'b001, 3'b000, 3'b101, 3'b101, 3'b000, 40);

    repeat (2) tick();
    chk("drain", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
